// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - posted-write store buffer between CPU MEM stage and data memory
// Stores queue in a FIFO and drain when the DM port is idle; loads forward from the youngest match.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_mem_read,
  input  logic                     cpu_mem_write,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_stall,
  output logic                     dm_read,
  output logic                     dm_write,
  output logic [AW-1:0]            dm_addr,
  output logic [DW-1:0]            dm_wdata,
  input  logic [DW-1:0]            dm_rdata,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] entry_addr [DEPTH];
  logic [DW-1:0] entry_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          full;
  logic          do_push;
  logic          do_pop;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] slot;

  assign full     = (count == CW'(DEPTH));
  assign do_push  = cpu_mem_write & ~full;
  // A queued store drains only when no load owns the port and no push competes for the slot.
  assign do_pop   = ~cpu_mem_read & (count != '0) & (~cpu_mem_write | full);

  assign cpu_stall = cpu_mem_write & full;
  assign sb_count  = count;
  assign sb_empty  = (count == '0);

  always_comb begin
    dm_read  = cpu_mem_read;
    dm_write = do_pop;
    dm_addr  = '0;
    dm_wdata = '0;
    if (cpu_mem_read) begin
      dm_addr = cpu_addr;
    end else if (do_pop) begin
      dm_addr  = entry_addr[head];
      dm_wdata = entry_data[head];
    end
  end

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if ((CW'(i) < count) && (entry_addr[slot] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[slot];
      end
    end
  end

  assign cpu_rdata = fwd_hit ? fwd_data : dm_rdata;

  always_ff @(posedge clk) begin
    if (do_push) begin
      entry_addr[tail] <= cpu_addr;
      entry_data[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - self-checking bench for dm_store_buffer
// A queue model plus a DM memory model are checked every cycle, alongside literal directed checks.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        cpu_mem_read;
  logic        cpu_mem_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty;

  dm_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        sbq[$];
  ent_t        wlog[$];
  logic [31:0] mem [256];
  int          vectors;
  int          miscompares;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dm_rdata = mem[dm_addr[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // DM memory and write log
  always @(posedge clk) begin
    if (reset && dm_write) begin
      mem[dm_addr[7:0]] <= dm_wdata;
      wlog.push_back('{dm_addr, dm_wdata});
    end
  end

  // Store-queue model: stores wait in order, leave one per free DM cycle
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sbq.delete();
    end else begin
      if (!cpu_mem_read && sbq.size() > 0 && (!cpu_mem_write || sbq.size() == DEPTH))
        void'(sbq.pop_front());
      else if (cpu_mem_write && sbq.size() < DEPTH)
        sbq.push_back('{cpu_addr, cpu_wdata});
    end
  end

  always @(negedge clk) begin : compare
    int          n;
    logic        e_full, e_drain;
    logic [31:0] e_addr, e_wdata, e_rdata;
    n       = sbq.size();
    e_full  = (n == DEPTH);
    e_drain = !cpu_mem_read && n > 0 && (!cpu_mem_write || e_full);
    e_addr  = 32'h0;
    e_wdata = 32'h0;
    if (cpu_mem_read) e_addr = cpu_addr;
    else if (e_drain) begin
      e_addr  = sbq[0].addr;
      e_wdata = sbq[0].data;
    end
    chk("m_count", {29'h0, sb_count}, n);
    chk("m_empty", {31'h0, sb_empty}, {31'h0, n == 0});
    chk("m_stall", {31'h0, cpu_stall}, {31'h0, cpu_mem_write && e_full});
    chk("m_dm_read", {31'h0, dm_read}, {31'h0, cpu_mem_read});
    chk("m_dm_write", {31'h0, dm_write}, {31'h0, e_drain});
    chk("m_dm_addr", dm_addr, e_addr);
    chk("m_dm_wdata", dm_wdata, e_wdata);
    if (cpu_mem_read) begin
      e_rdata = mem[cpu_addr[7:0]];
      foreach (sbq[i]) if (sbq[i].addr == cpu_addr) e_rdata = sbq[i].data;
      chk("m_rdata", cpu_rdata, e_rdata);
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_mem_read  = rd;
    cpu_mem_write = wr;
    cpu_addr      = a;
    cpu_wdata     = d;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    drive(rd, wr, a, d);
    tick();
  endtask

  initial begin
    int lb;
    int stalls;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h24]    = 32'h1234_5678;
    reset         = 1'b0;
    cpu_mem_read  = 1'b0;
    cpu_mem_write = 1'b0;
    cpu_addr      = 32'h0;
    cpu_wdata     = 32'h0;

    // 1: reset then idle
    tick(); tick();
    #2;
    chk("t1_rst_empty", {31'h0, sb_empty}, 32'h1);
    chk("t1_rst_dm_addr", dm_addr, 32'h0);
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t1_count", {29'h0, sb_count}, 32'h0);

    // 2: single store drains on the idle cycle
    drive(0, 1, 32'h10, 32'hAAAA_0001);
    chk("t2_push_nowrite", {31'h0, dm_write}, 32'h0);
    tick();
    drive(0, 0, 0, 0);
    chk("t2_count1", {29'h0, sb_count}, 32'h1);
    chk("t2_drain_we", {31'h0, dm_write}, 32'h1);
    chk("t2_drain_addr", dm_addr, 32'h10);
    chk("t2_drain_data", dm_wdata, 32'hAAAA_0001);
    tick();
    chk("t2_count0", {29'h0, sb_count}, 32'h0);
    drive(1, 0, 32'h10, 0);
    chk("t2_readback", cpu_rdata, 32'hAAAA_0001);
    tick();

    // 3: youngest-match forwarding
    lb = wlog.size();
    step(0, 1, 32'h20, 32'h1);
    step(0, 1, 32'h20, 32'h2);
    drive(1, 0, 32'h20, 0);
    chk("t3_fwd", cpu_rdata, 32'h2);
    chk("t3_dm_read", {31'h0, dm_read}, 32'h1);
    chk("t3_no_drain", {31'h0, dm_write}, 32'h0);
    tick();
    drive(1, 0, 32'h24, 0);
    chk("t3_miss", cpu_rdata, 32'h1234_5678);
    tick();
    repeat (3) step(0, 0, 0, 0);
    chk("t3_nwrites", wlog.size() - lb, 2);
    chk("t3_w0", wlog[lb].data, 32'h1);
    chk("t3_w1", wlog[lb+1].data, 32'h2);
    chk("t3_w1_addr", wlog[lb+1].addr, 32'h20);

    // 4: full buffer, one stall cycle, pointer wrap
    lb = wlog.size();
    for (int i = 0; i < 4; i++) step(0, 1, i, 32'h100 + i);
    chk("t4_full", {29'h0, sb_count}, 32'h4);
    drive(0, 1, 32'h4, 32'h104);
    stalls = 0;
    for (int k = 0; k < 5 && cpu_stall; k++) begin
      stalls++;
      tick();
      #2;
    end
    chk("t4_stall_cycles", stalls, 1);
    tick();
    chk("t4_full_again", {29'h0, sb_count}, 32'h4);
    repeat (6) step(0, 0, 0, 0);
    chk("t4_nwrites", wlog.size() - lb, 5);
    for (int i = 0; i < 5; i++) begin
      if (lb + i < wlog.size()) chk("t4_order", wlog[lb+i].addr, i);
    end

    // 5: loads hold off drains
    for (int i = 0; i < 3; i++) step(0, 1, 32'h30 + i, 32'h300 + i);
    lb = wlog.size();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h31, 0);
      chk("t5_no_drain", {31'h0, dm_write}, 32'h0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("t5_resume_we", {31'h0, dm_write}, 32'h1);
    chk("t5_resume_addr", dm_addr, 32'h30);
    tick();
    repeat (3) step(0, 0, 0, 0);
    chk("t5_nwrites", wlog.size() - lb, 3);

    // 6: async reset discards queued stores
    lb = wlog.size();
    for (int i = 0; i < 3; i++) step(0, 1, 32'h40 + i, 32'h400 + i);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("t6_count_now", {29'h0, sb_count}, 32'h0);
    chk("t6_empty_now", {31'h0, sb_empty}, 32'h1);
    chk("t6_no_we", {31'h0, dm_write}, 32'h0);
    tick();
    reset = 1'b1;
    repeat (4) step(0, 0, 0, 0);
    chk("t6_no_writes", wlog.size() - lb, 0);
    drive(1, 0, 32'h40, 0);
    chk("t6_mem_intact", cpu_rdata, 32'h0);
    tick();
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
